// File: rtl/led_pulse_stretcher.sv
// Event-to-LED pulse stretcher: each accepted edge on event_in becomes one
// fixed-length LED-on interval followed by a fixed LED-off gap. Events that
// arrive while a blink is running are queued in a saturating counter.
module led_pulse_stretcher #(
  parameter int unsigned ON_CYCLES   = 13_500_000,
  parameter int unsigned OFF_CYCLES  = 6_750_000,
  parameter int unsigned MAX_PENDING = 15,
  parameter bit          TRIG_FALL   = 1'b1,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic                             clk,
  input  logic                             nrst,
  input  logic                             event_in,
  output logic                             led_out,
  output logic                             busy,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending,
  output logic                             overflow
);

  localparam int unsigned PW   = $clog2(MAX_PENDING + 1);
  localparam int unsigned TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE    = TW'(1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
  localparam logic [PW-1:0] P_ONE    = PW'(1);

  // Input level that counts as "event asserted", and LED drive levels.
  localparam logic ACT_LVL  = ~TRIG_FALL;
  localparam logic LED_LIT  = ~ACTIVE_LOW;
  localparam logic LED_DARK = ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE,
    ON,
    GAP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [PW-1:0]   pend_q, pend_d;
  logic            ovf_q, ovf_d;
  logic            led_q, led_d;
  logic            busy_q, busy_d;
  logic            prev_q;
  logic            armed_q;
  logic            ev;
  logic            queue_ev;

  // armed_q suppresses the first sampled cycle after reset, so an input that
  // is already at the active level when reset releases is not seen as an edge.
  assign ev = armed_q && (event_in == ACT_LVL) && (prev_q != ACT_LVL);

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

  // State, timer, queue and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= LED_DARK;
      busy_q  <= 1'b0;
      prev_q  <= ~ACT_LVL;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      prev_q  <= event_in;
      armed_q <= 1'b1;
    end
  end

  // Next-state, timer reload, queue update and output decode.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    pend_d   = pend_q;
    ovf_d    = 1'b0;
    queue_ev = 1'b0;

    case (state_q)
      IDLE: begin
        if (ev) begin
          state_d = ON;
          timer_d = ON_LOAD;
        end else if (pend_q != '0) begin
          state_d = ON;
          timer_d = ON_LOAD;
          pend_d  = pend_q - P_ONE;
        end
      end

      ON: begin
        queue_ev = ev;
        if (timer_q == '0) begin
          state_d = GAP;
          timer_d = OFF_LOAD;
        end else begin
          timer_d = timer_q - T_ONE;
        end
      end

      GAP: begin
        if (timer_q != '0) begin
          timer_d  = timer_q - T_ONE;
          queue_ev = ev;
        end else if (ev) begin
          // A fresh edge on the final gap cycle starts the next blink itself.
          state_d = ON;
          timer_d = ON_LOAD;
        end else if (pend_q != '0) begin
          state_d = ON;
          timer_d = ON_LOAD;
          pend_d  = pend_q - P_ONE;
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    if (queue_ev) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + P_ONE;
      end
    end

    led_d  = (state_d == ON) ? LED_LIT : LED_DARK;
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Scoreboard bench for led_pulse_stretcher: stimulus pushes the expected
// output changes (cycle + value); a monitor compares every observed change.
module tb_led_pulse_stretcher;

  logic       clk = 1'b0;
  logic       nrst = 1'b1;
  logic       event_in = 1'b1;
  logic       led_out;
  logic       busy;
  logic [1:0] pending;
  logic       overflow;

  always #5 clk = ~clk;

  led_pulse_stretcher #(
    .ON_CYCLES  (4),
    .OFF_CYCLES (3),
    .MAX_PENDING(3),
    .TRIG_FALL  (1'b1),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .event_in(event_in),
    .led_out (led_out),
    .busy    (busy),
    .pending (pending),
    .overflow(overflow)
  );

  typedef struct packed {
    logic       led;
    logic       busy;
    logic [1:0] pend;
    logic       ovf;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  obs_t last;

  // cyc equals n between posedge n and posedge n+1
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every change of the output tuple must match the next expectation.
  always @(negedge clk) begin
    obs_t cur;
    exp_t e;
    cur = {led_out, busy, pending, overflow};
    if (!nrst) begin
      last = cur;
    end else if (cur != last) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change cyc=%0d got=%b (led,busy,pend,ovf) required no change", cyc, cur);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.o != cur) begin
          failures++;
          $display("FAIL output_change cyc=%0d got=%b (led,busy,pend,ovf) required cyc=%0d value=%b",
                   cyc, cur, e.cyc, e.o);
        end
      end
      last = cur;
    end
  end

  function automatic void push(input int c, input logic l, input logic b,
                               input logic [1:0] p, input logic o);
    exp_t e;
    e.cyc = c;
    e.o   = {l, b, p, o};
    q.push_back(e);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns the index of the posedge that will sample the next driven value.
  task automatic start(output int k);
    @(negedge clk);
    #1;
    k = cyc + 1;
  endtask

  // Drives one event_in level per cycle; the first char is sampled at edge k.
  task automatic play(input string pat);
    for (int i = 0; i < pat.len(); i++) begin
      if (i != 0) begin
        @(negedge clk);
        #1;
      end
      event_in = (pat[i] == 8'h31);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout required=completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;

    // 1: reset values, then release with the input already held active
    event_in = 1'b1;
    #2 nrst = 1'b0;
    #1;
    chk("rst_led", int'(led_out), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overflow", int'(overflow), 0);
    @(negedge clk);
    event_in = 1'b0;
    @(negedge clk);
    #1 nrst = 1'b1;
    idle(20);
    chk("held_low_led", int'(led_out), 1);
    chk("held_low_busy", int'(busy), 0);
    chk("t1_queue_empty", q.size(), 0);
    @(negedge clk);
    #1 event_in = 1'b1;
    idle(3);

    // 2: single blink, 4 cycles lit then 3 cycles dark
    start(k);
    push(k,     1'b0, 1'b1, 2'd0, 1'b0);
    push(k + 4, 1'b1, 1'b1, 2'd0, 1'b0);
    push(k + 7, 1'b1, 1'b0, 2'd0, 1'b0);
    play("001");
    idle(12);
    chk("t2_queue_empty", q.size(), 0);

    // 3: two edges queued during ON, three back-to-back blinks of period 7
    start(k);
    push(k,      1'b0, 1'b1, 2'd0, 1'b0);
    push(k + 2,  1'b0, 1'b1, 2'd1, 1'b0);
    push(k + 4,  1'b1, 1'b1, 2'd2, 1'b0);
    push(k + 7,  1'b0, 1'b1, 2'd1, 1'b0);
    push(k + 11, 1'b1, 1'b1, 2'd1, 1'b0);
    push(k + 14, 1'b0, 1'b1, 2'd0, 1'b0);
    push(k + 18, 1'b1, 1'b1, 2'd0, 1'b0);
    push(k + 21, 1'b1, 1'b0, 2'd0, 1'b0);
    play("010101");
    idle(25);
    chk("t3_queue_empty", q.size(), 0);

    // 4: edges every 2 cycles from IDLE; the queue refills to 3 after the
    // first dequeue, so the 6th edge is the one dropped (5 blinks in total)
    start(k);
    push(k,      1'b0, 1'b1, 2'd0, 1'b0);
    push(k + 2,  1'b0, 1'b1, 2'd1, 1'b0);
    push(k + 4,  1'b1, 1'b1, 2'd2, 1'b0);
    push(k + 6,  1'b1, 1'b1, 2'd3, 1'b0);
    push(k + 7,  1'b0, 1'b1, 2'd2, 1'b0);
    push(k + 8,  1'b0, 1'b1, 2'd3, 1'b0);
    push(k + 10, 1'b0, 1'b1, 2'd3, 1'b1);
    push(k + 11, 1'b1, 1'b1, 2'd3, 1'b0);
    push(k + 14, 1'b0, 1'b1, 2'd2, 1'b0);
    push(k + 18, 1'b1, 1'b1, 2'd2, 1'b0);
    push(k + 21, 1'b0, 1'b1, 2'd1, 1'b0);
    push(k + 25, 1'b1, 1'b1, 2'd1, 1'b0);
    push(k + 28, 1'b0, 1'b1, 2'd0, 1'b0);
    push(k + 32, 1'b1, 1'b1, 2'd0, 1'b0);
    push(k + 35, 1'b1, 1'b0, 2'd0, 1'b0);
    play("010101010101");
    idle(30);
    chk("t4_queue_empty", q.size(), 0);

    // 5: asynchronous reset on the 2nd ON cycle with pending = 2
    start(k);
    push(k,     1'b0, 1'b1, 2'd0, 1'b0);
    push(k + 2, 1'b0, 1'b1, 2'd1, 1'b0);
    push(k + 4, 1'b1, 1'b1, 2'd2, 1'b0);
    push(k + 6, 1'b1, 1'b1, 2'd3, 1'b0);
    push(k + 7, 1'b0, 1'b1, 2'd2, 1'b0);
    play("01010101");
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("t5_pre_pending", int'(pending), 2);
    chk("t5_pre_led", int'(led_out), 0);
    nrst = 1'b0;
    #1;
    chk("t5_rst_led", int'(led_out), 1);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_pending", int'(pending), 0);
    chk("t5_rst_overflow", int'(overflow), 0);
    @(negedge clk);
    #1 nrst = 1'b1;
    idle(20);
    chk("t5_queue_empty", q.size(), 0);

    // 6: edge on the final GAP cycle goes straight back to ON
    start(k);
    push(k,      1'b0, 1'b1, 2'd0, 1'b0);
    push(k + 4,  1'b1, 1'b1, 2'd0, 1'b0);
    push(k + 7,  1'b0, 1'b1, 2'd0, 1'b0);
    push(k + 11, 1'b1, 1'b1, 2'd0, 1'b0);
    push(k + 14, 1'b1, 1'b0, 2'd0, 1'b0);
    play("011111101");
    idle(20);
    chk("t6_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
